// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, response
// error codes and controller states.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_SIZE     = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_RESP     = 2'b10
    } state_e;

endpackage

// File: rtl/mem_lane_ext.sv
// Picks the addressed byte/half lane out of a memory word and sign- or
// zero-extends it to 32 bits; word accesses pass straight through.
module mem_lane_ext
    import mem_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        half_lane = word[{addr_lo[1], 4'b0000} +: 16];
        data      = word;
        case (size)
            SZ_BYTE: data = {{24{is_signed & byte_lane[7]}}, byte_lane};
            SZ_HALF: data = {{16{is_signed & half_lane[15]}}, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: one outstanding request to a multi-cycle word memory,
// with store lane placement, load lane extension and an ack timeout.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] cnt;
    err_e             req_err;
    logic             timed_out;
    logic [3:0]       store_be;
    logic [31:0]      store_wdata;
    logic [31:0]      load_ext;

    logic             lat_we;
    logic             lat_signed;
    logic [1:0]       lat_size;
    logic [1:0]       lat_addr_lo;

    assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));

    // Handshake outputs come straight from the state register, so reset drops
    // mem_req the moment it is asserted.
    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign mem_req    = (state == ST_MEM_WAIT);
    assign resp_valid = (state == ST_RESP);

    always_comb begin
        req_err = ERR_OK;
        case (req_size)
            SZ_HALF: if (req_addr[0])            req_err = ERR_MISALIGN;
            SZ_WORD: if (req_addr[1:0] != 2'b00) req_err = ERR_MISALIGN;
            SZ_ILL:                              req_err = ERR_SIZE;
            default:                             req_err = ERR_OK;
        endcase
    end

    // Loads always fetch the full word; stores replicate the data across lanes
    // and let the byte enables pick the target bytes.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = req_wdata;
        if (req_we) begin
            case (req_size)
                SZ_BYTE: begin
                    store_be    = 4'b0001 << req_addr[1:0];
                    store_wdata = {4{req_wdata[7:0]}};
                end
                SZ_HALF: begin
                    store_be    = 4'b0011 << {req_addr[1], 1'b0};
                    store_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    store_be    = 4'b1111;
                    store_wdata = req_wdata;
                end
            endcase
        end
    end

    mem_lane_ext u_lane_ext (
        .addr_lo   (lat_addr_lo),
        .size      (lat_size),
        .is_signed (lat_signed),
        .word      (mem_rdata),
        .data      (load_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (req_valid) next_state = (req_err == ERR_OK) ? ST_MEM_WAIT : ST_RESP;
            ST_MEM_WAIT: if (mem_ack || timed_out) next_state = ST_RESP;
            ST_RESP:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Ack takes priority over the timeout when both land on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_signed  <= 1'b0;
            lat_size    <= 2'b00;
            lat_addr_lo <= 2'b00;
            resp_rdata  <= '0;
            resp_rd     <= '0;
            resp_err    <= ERR_OK;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we      <= req_we;
                        lat_signed  <= req_signed;
                        lat_size    <= req_size;
                        lat_addr_lo <= req_addr[1:0];
                        resp_rd     <= req_rd;
                        resp_rdata  <= '0;
                        resp_err    <= req_err;
                        cnt         <= '0;
                        if (req_err == ERR_OK) begin
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= store_be;
                            mem_wdata <= store_wdata;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        resp_err   <= ERR_OK;
                        resp_rdata <= lat_we ? 32'h0 : load_ext;
                    end else if (timed_out) begin
                        resp_err   <= ERR_TIMEOUT;
                    end else begin
                        cnt        <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses are queued at issue
// and compared when resp_valid appears; the memory side is driven cycle by cycle.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  err;
    } resp_t;

    resp_t sb_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] v;
        v = word;
        if (size == 2'b00) begin
            v = (word >> (addr[1:0] * 8)) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (word >> (addr[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [1:0] size, input logic [31:0] addr);
        if (!we || size == 2'b10) return 4'b1111;
        if (size == 2'b01)        return addr[1] ? 4'b1100 : 4'b0011;
        case (addr[1:0])
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
        if (size == 2'b00) return {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
        if (size == 2'b01) return {wdata[15:0], wdata[15:0]};
        return wdata;
    endfunction

    // One request issued at a negedge; ack_at is the wait cycle (1-based) on
    // which mem_ack is driven, 0 for never.
    task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [4:0] rd, input int ack_at,
                                  input logic [31:0] rword, input logic [31:0] exp_rdata,
                                  input logic [1:0] exp_err, input logic [3:0] exp_be,
                                  input logic [31:0] exp_wdata);
        int    resp_at;
        logic  mem_path;
        resp_t r;
        resp_t got;
        mem_path = (exp_err == ERR_OK) || (exp_err == ERR_TIMEOUT);
        resp_at  = !mem_path ? 1 : ((ack_at > 0) ? ack_at + 1 : TIMEOUT + 1);
        check_output("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        r.rdata    = exp_rdata;
        r.rd       = rd;
        r.err      = exp_err;
        sb_q.push_back(r);
        @(negedge clk);
        req_valid  = 1'b0;
        for (int k = 1; k <= resp_at; k++) begin
            check_output("mem_req", {31'b0, mem_req}, {31'b0, (mem_path && k < resp_at)});
            check_output("resp_valid", {31'b0, resp_valid}, {31'b0, (k == resp_at)});
            check_output("busy", {31'b0, busy}, 32'd1);
            if (mem_path && k == 1) begin
                check_output("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check_output("mem_we", {31'b0, mem_we}, {31'b0, we});
                check_output("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
                if (we) check_output("mem_wdata", mem_wdata, exp_wdata);
            end
            if (resp_valid) begin
                check_output("sb_depth", sb_q.size(), 32'd1);
                if (sb_q.size() != 0) begin
                    got = sb_q.pop_front();
                    check_output("resp_rdata", resp_rdata, got.rdata);
                    check_output("resp_rd", {27'b0, resp_rd}, {27'b0, got.rd});
                    check_output("resp_err", {30'b0, resp_err}, {30'b0, got.err});
                end
            end
            mem_rdata = (k == ack_at) ? rword : ~rword;
            mem_ack   = (k == ack_at);
            @(negedge clk);
            mem_ack   = 1'b0;
        end
        check_output("resp_valid_once", {31'b0, resp_valid}, 32'd0);
        check_output("req_ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] d;
        logic        we;
        logic        sg;
        int          ack;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rd     = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        @(negedge clk);
        @(negedge clk);
        check_output("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_output("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_output("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check_output("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check_output("rst_resp_err", {30'b0, resp_err}, 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        apply_stimulus(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 5'd1, 1, 32'h80FF_1234,
                       32'hFFFF_FF80, ERR_OK, 4'b1111, 32'h0);
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 5'd2, 1, 32'h8001_7FFF,
                       32'h0000_8001, ERR_OK, 4'b1111, 32'h0);
        apply_stimulus(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 5'd3, 2, 32'h8001_7FFF,
                       32'hFFFF_8001, ERR_OK, 4'b1111, 32'h0);
        apply_stimulus(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56AB, 5'd4, 1, 32'h5555_5555,
                       32'h0, ERR_OK, 4'b0010, 32'hABAB_ABAB);
        apply_stimulus(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h1234_BEEF, 5'd5, 3, 32'h0,
                       32'h0, ERR_OK, 4'b1100, 32'hBEEF_BEEF);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 5'd6, 0, 32'h0,
                       32'h0, ERR_MISALIGN, 4'b1111, 32'h0);
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h0000_4001, 32'h0, 5'd7, 0, 32'h0,
                       32'h0, ERR_MISALIGN, 4'b1111, 32'h0);
        apply_stimulus(1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0, 5'd8, 0, 32'h0,
                       32'h0, ERR_SIZE, 4'b1111, 32'h0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 5'd9, 0, 32'h1111_2222,
                       32'h0, ERR_TIMEOUT, 4'b1111, 32'h0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0, 5'd10, TIMEOUT, 32'h1357_9BDF,
                       32'h1357_9BDF, ERR_OK, 4'b1111, 32'h0);
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h0000_6008, 32'hA5A5_5A5A, 5'd11, 0, 32'h0,
                       32'h0, ERR_TIMEOUT, 4'b1111, 32'hA5A5_5A5A);

        for (int i = 0; i < 24; i++) begin
            sz  = 2'($urandom_range(0, 2));
            we  = 1'($urandom_range(0, 1));
            sg  = 1'($urandom_range(0, 1));
            a   = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            w   = $urandom;
            d   = $urandom;
            ack = $urandom_range(0, TIMEOUT);
            apply_stimulus(we, sz, sg, a, d, 5'(i + 12), ack, w,
                           (we || ack == 0) ? 32'h0 : model_load(sz, sg, a, w),
                           (ack == 0) ? ERR_TIMEOUT : ERR_OK,
                           model_be(we, sz, a), model_wdata(sz, d));
        end

        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0000_5000;
        req_rd    = 5'd30;
        @(negedge clk);
        req_valid = 1'b0;
        check_output("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check_output("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_output("async_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check_output("rst_no_resp", {31'b0, resp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_output("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 5'd31, 1, 32'hCAFE_F00D,
                       32'hCAFE_F00D, ERR_OK, 4'b1111, 32'h0);

        check_output("sb_leftover", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
